// File: rtl/seg7_pkg.sv
// Shared constants for the four-digit multiplexed seven-segment scanner.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int DIGITS = 4;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    typedef enum logic [1:0] {
        SLOT_ONES_A = 2'd0,
        SLOT_TENS_A = 2'd1,
        SLOT_ONES_B = 2'd2,
        SLOT_TENS_B = 2'd3
    } slot_e;

endpackage

// File: rtl/seg7_scan_bcd_to_seg7.sv
// BCD to active-low seven-segment decoder; non-decimal codes show a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed display scanner with frame-aligned input latching,
// leading-zero blanking on the tens digits and whole-display blinking.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] tens_a,
    input  logic [3:0] ones_a,
    input  logic [3:0] tens_b,
    input  logic [3:0] ones_b,
    input  logic       blank_lz,
    input  logic       blink_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam int IW = $clog2(DIGITS);

    logic [PW-1:0] presc;
    logic [IW-1:0] idx;
    logic [3:0]    sh_ta;
    logic [3:0]    sh_oa;
    logic [3:0]    sh_tb;
    logic [3:0]    sh_ob;
    logic [FW-1:0] fcnt;
    logic          phase;

    logic          tick;
    logic          frame_tick;
    logic [3:0]    digit;
    logic          is_tens;
    logic          blank;
    logic [6:0]    dec_seg;

    assign tick       = (presc == PW'(REFRESH_DIV - 1));
    assign frame_tick = tick && (idx == IW'(DIGITS - 1));
    assign dp         = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick)
                idx <= idx + 1'b1;
        end
    end

    // Shadow copies only change at the frame boundary so a frame never tears.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_ta <= '0;
            sh_oa <= '0;
            sh_tb <= '0;
            sh_ob <= '0;
        end else if (frame_tick) begin
            sh_ta <= tens_a;
            sh_oa <= ones_a;
            sh_tb <= tens_b;
            sh_ob <= ones_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fcnt  <= '0;
            phase <= 1'b1;
        end else if (!blink_en) begin
            fcnt  <= '0;
            phase <= 1'b1;
        end else if (frame_tick) begin
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                fcnt  <= '0;
                phase <= !phase;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    always_comb begin
        digit   = sh_oa;
        is_tens = 1'b0;
        unique case (slot_e'(idx))
            SLOT_ONES_A: digit = sh_oa;
            SLOT_TENS_A: begin
                digit   = sh_ta;
                is_tens = 1'b1;
            end
            SLOT_ONES_B: digit = sh_ob;
            SLOT_TENS_B: begin
                digit   = sh_tb;
                is_tens = 1'b1;
            end
        endcase
        blank = !phase || (blank_lz && is_tens && digit == 4'd0);
    end

    bcd_to_seg7 u_dec (
        .bcd (digit),
        .seg (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            an         <= 4'hF;
            seg        <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            an         <= blank ? 4'hF : ~(4'b0001 << idx);
            seg        <= dec_seg;
            frame_done <= frame_tick;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: time-based reference model plus
// directed literal frame checks and randomized input traffic.
module tb_seg7_scan;

    localparam int DIV = 4;
    localparam int BF  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] tens_a, ones_a, tens_b, ones_b;
    logic       blank_lz, blink_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp, frame_done;

    int checks = 0;
    int fails  = 0;

    seg7_scan #(.REFRESH_DIV(DIV), .BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .reset      (reset),
        .tens_a     (tens_a),
        .ones_a     (ones_a),
        .tens_b     (tens_b),
        .ones_b     (ones_b),
        .blank_lz   (blank_lz),
        .blink_en   (blink_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position in the scan is derived from elapsed cycles.
    int         t;
    int         sh [4];
    int         fcnt;
    bit         phase;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_fd;
    bit         model_ok = 0;

    always @(posedge clk) begin
        int idx;
        int d;
        bit tick;
        bit blank;
        if (reset) begin
            t = 0;
            for (int i = 0; i < 4; i++) sh[i] = 0;
            fcnt = 0;
            phase = 1;
            exp_an = 4'hF;
            exp_seg = 7'h7F;
            exp_fd = 0;
        end else begin
            idx = (t / DIV) % 4;
            tick = (t % DIV) == DIV - 1;
            d = sh[idx];
            blank = !phase || (blank_lz && (idx % 2 == 1) && d == 0);
            exp_an = blank ? 4'hF : (4'hF ^ 4'(1 << idx));
            exp_seg = seg_of(d);
            exp_fd = tick && idx == 3;
            if (exp_fd) begin
                sh[0] = ones_a;
                sh[1] = tens_a;
                sh[2] = ones_b;
                sh[3] = tens_b;
                if (blink_en) begin
                    fcnt++;
                    if (fcnt == BF) begin
                        fcnt = 0;
                        phase = !phase;
                    end
                end
            end
            if (!blink_en) begin
                fcnt = 0;
                phase = 1;
            end
            t++;
        end
        model_ok = 1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("an", an, exp_an);
            chk("seg", seg, exp_seg);
            chk("frame_done", frame_done, exp_fd);
            chk("dp", dp, 1);
        end
    end

    task automatic wait_fd();
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (frame_done) got = 1;
        end
        chk("fd_timeout", got, 1);
    endtask

    logic [3:0] an_lit  [4];
    logic [6:0] seg_lit [4];

    initial begin
        bit found;
        an_lit[0] = 4'b1110; seg_lit[0] = 7'b0100100;
        an_lit[1] = 4'b1101; seg_lit[1] = 7'b0011001;
        an_lit[2] = 4'b1011; seg_lit[2] = 7'b1111000;
        an_lit[3] = 4'b0111; seg_lit[3] = 7'b1000000;

        tens_a = 4; ones_a = 2; tens_b = 0; ones_b = 7;
        blank_lz = 0; blink_en = 0; reset = 1;
        repeat (3) @(negedge clk);
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_fd", frame_done, 0);
        reset = 0;

        found = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (an == 4'b1110) found = 1;
        end
        chk("an_first", found, 1);

        wait_fd();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("lit_an", an, an_lit[k / 4]);
            chk("lit_seg", seg, seg_lit[k / 4]);
        end

        blank_lz = 1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k / 4 == 3) chk("lz_an3", an, 4'hF);
            if (k / 4 == 2) begin
                chk("lz_an2", an, 4'b1011);
                chk("lz_seg2", seg, 7'b1111000);
            end
        end

        repeat (6) @(negedge clk);
        tens_a = 9;
        @(negedge clk);
        chk("tear_an", an, 4'b1101);
        chk("tear_seg", seg, 7'b0011001);
        wait_fd();
        repeat (5) @(negedge clk);
        chk("new_an", an, 4'b1101);
        chk("new_seg", seg, 7'b0010000);

        blank_lz = 0;
        ones_b = 12;
        repeat (40) @(negedge clk);

        blink_en = 1;
        repeat (130) @(negedge clk);
        wait_fd();
        repeat (10) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("rst_mid_an", an, 4'b1110);
        repeat (80) @(negedge clk);

        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            reset = 0;
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: tens_a = 4'($urandom_range(0, 15));
                    1: ones_a = 4'($urandom_range(0, 15));
                    2: tens_b = 4'($urandom_range(0, 15));
                    default: ones_b = 4'($urandom_range(0, 15));
                endcase
            end
            if ($urandom_range(0, 31) == 0) blank_lz = !blank_lz;
            if ($urandom_range(0, 199) == 0) blink_en = !blink_en;
            if ($urandom_range(0, 299) == 0) reset = 1;
        end
        reset = 0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
